// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids, opcodes.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_LSU = 2'd1,
    RD_EXT = 2'd2
  } state_e;

  typedef enum logic {
    LSU = 1'b0,
    EXT = 1'b1
  } port_e;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

endpackage

// File: rtl/dmem_arb_rr2.sv
// Two-input arbiter, one-hot grant. Round-robin with a last-granted pointer when
// DMEM_ARB_RR_EN is defined; otherwise fixed priority (bit 0 = LSU wins).
module dmem_arb_rr2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
`ifdef DMEM_ARB_RR_EN
  ,
  input  logic       clk,
  input  logic       rst_n
`endif
);

`ifdef DMEM_ARB_RR_EN
  port_e r_last;

  // On a tie the port that was not granted last wins.
  always_comb begin
    o_gnt = '0;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last == EXT) ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= EXT;
    end else if (o_gnt[0]) begin
      r_last <= LSU;
    end else if (o_gnt[1]) begin
      r_last <= EXT;
    end
  end
`else
  always_comb begin
    o_gnt    = '0;
    o_gnt[0] = i_req[0];
    o_gnt[1] = i_req[1] & ~i_req[0];
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: LSU and EXT requesters share one active-low SRAM port.
// Arbitration policy selected by DMEM_ARB_RR_EN (round-robin) vs fixed LSU priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_mask,
  output logic            lsu_gnt,
  output logic            lsu_rvalid,
  output logic [DW-1:0]   lsu_rdata,
  input  logic            ext_req,
  input  logic            ext_we,
  input  logic [AW-1:0]   ext_addr,
  input  logic [DW-1:0]   ext_wdata,
  input  logic [DW/8-1:0] ext_mask,
  output logic            ext_gnt,
  output logic            ext_rvalid,
  output logic [DW-1:0]   ext_rdata,
  output logic            mem_cs,
  output logic            mem_wr,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_mask,
  input  logic [DW-1:0]   mem_rdata
);

  logic [1:0]      w_req;
  logic [1:0]      w_gnt;
  logic            w_any;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [DW/8-1:0] w_sel_mask;
  state_e          w_state_nxt;
  state_e          r_state;
  logic [DW-1:0]   r_lsu_rdata;
  logic [DW-1:0]   r_ext_rdata;

  // Requests are masked while in reset so no grant leaks out combinationally.
  assign w_req = {ext_req & rst_n, lsu_req & rst_n};

  dmem_arb_rr2 u_arb (
    .i_req (w_req),
    .o_gnt (w_gnt)
`ifdef DMEM_ARB_RR_EN
    ,
    .clk   (clk),
    .rst_n (rst_n)
`endif
  );

  assign lsu_gnt = w_gnt[0];
  assign ext_gnt = w_gnt[1];
  assign w_any   = |w_gnt;

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_mask  = '0;
    if (w_gnt[0]) begin
      w_sel_we    = lsu_we;
      w_sel_addr  = lsu_addr;
      w_sel_wdata = lsu_wdata;
      w_sel_mask  = lsu_mask;
    end else if (w_gnt[1]) begin
      w_sel_we    = ext_we;
      w_sel_addr  = ext_addr;
      w_sel_wdata = ext_wdata;
      w_sel_mask  = ext_mask;
    end
  end

  assign mem_cs    = ~w_any;
  assign mem_wr    = ~(w_any & w_sel_we);
  assign mem_addr  = w_sel_addr;
  assign mem_wdata = w_sel_wdata;
  assign mem_mask  = (w_any & w_sel_we) ? w_sel_mask : '0;

  always_comb begin
    w_state_nxt = IDLE;
    if (w_gnt[0] && !lsu_we) begin
      w_state_nxt = RD_LSU;
    end else if (w_gnt[1] && !ext_we) begin
      w_state_nxt = RD_EXT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response routing follows the state (the access issued last cycle), not the
  // current grant, so a new access can be issued while a load completes.
  assign lsu_rvalid = (r_state == RD_LSU);
  assign ext_rvalid = (r_state == RD_EXT);
  assign lsu_rdata  = lsu_rvalid ? mem_rdata : r_lsu_rdata;
  assign ext_rdata  = ext_rvalid ? mem_rdata : r_ext_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lsu_rdata <= '0;
      r_ext_rdata <= '0;
    end else begin
      if (lsu_rvalid) r_lsu_rdata <= mem_rdata;
      if (ext_rvalid) r_ext_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width; byte mask width is DW/8.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 lsu_req  input  1  load/store unit access request.
REQ-006 lsu_we  input  1  1 = store, 0 = load.
REQ-007 lsu_addr / lsu_wdata / lsu_mask  input  AW / DW / DW/8  LSU access address, store data and byte mask.
REQ-008 lsu_gnt  output  1  LSU request accepted this cycle.
REQ-009 lsu_rvalid / lsu_rdata  output  1 / DW  LSU load data valid, and the load data.
REQ-010 ext_req, ext_we, ext_addr, ext_wdata, ext_mask, ext_gnt, ext_rvalid, ext_rdata  same directions/widths  second requester port (debug/DMA bridge).
REQ-011 mem_cs  output  1  data memory chip select, active-low.
REQ-012 mem_wr  output  1  data memory write enable, active-low (0 = store, 1 = load).
REQ-013 mem_addr / mem_wdata / mem_mask  output  AW / DW / DW/8  memory address, store data and byte mask.
REQ-014 mem_rdata  input  DW  memory read data, valid one cycle after a load is issued.

Function
REQ-015 A requester SHALL hold req and its payload stable until it sees gnt high; gnt is high for exactly one cycle per accepted access.
REQ-016 Arbitration SHALL be combinational on the current cycle's req inputs: the winner's gnt and the mem_* outputs are driven in the same cycle.
REQ-017 Exactly one gnt SHALL be high per cycle at most; mem_cs=0 iff a gnt is high, else mem_cs=1, mem_wr=1 and mem_mask=0.
REQ-018 On a granted store, mem_wr=0 and mem_wdata/mem_mask/mem_addr come from the winner; no rvalid is ever produced for a store.
REQ-019 On a granted load, mem_wr=1 and mem_mask=0; the winner's rvalid SHALL be high in the following cycle, with rdata = mem_rdata.
REQ-020 The FSM SHALL have states IDLE, RD_LSU and RD_EXT; a granted load moves it to RD_LSU or RD_EXT, otherwise it moves to IDLE.
REQ-021 A new grant SHALL be allowed while in RD_LSU/RD_EXT (fully pipelined, one access per cycle); rvalid is routed by the current state, not by the current grant.
REQ-022 rdata on a port SHALL hold its last loaded value when rvalid is low.
REQ-023 A priority pointer SHALL record the last granted port; on simultaneous requests the port that was not last granted wins.
REQ-024 A single requester SHALL be granted every cycle with no bubble, and the pointer updates only on a grant.
REQ-025 If rst_n asserts mid-access, an outstanding rvalid SHALL be dropped and the FSM returns to IDLE.

Reset
REQ-026 While rst_n=0: FSM=IDLE, pointer=EXT (so LSU wins the first tie), mem_cs=1, mem_wr=1, mem_mask=0, gnts=0, rvalids=0, rdata=0, mem_addr=0, mem_wdata=0.

Configuration
REQ-027 With DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin as in REQ-023.
REQ-028 Without DMEM_ARB_RR_EN, LSU SHALL have fixed priority over EXT; the pointer register is removed and REQ-023 does not apply.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, RD_LSU, RD_EXT), the port-id enum (LSU, EXT), and the opcode constants LOAD=7'b0000011 and STORE=7'b0100011.
REQ-030 The block SHALL contain one sub-module, dmem_arb_rr2: a 2-input arbiter with req in and one-hot gnt out, holding the pointer.

Verification
REQ-031 Reset release, no requests -> mem_cs=1, mem_wr=1, both gnt=0, both rvalid=0 for 10 cycles.
REQ-032 LSU load at addr 0x10 with mem_rdata=0xDEADBEEF -> lsu_gnt in cycle N, mem_cs=0 and mem_wr=1 in cycle N, lsu_rvalid=1 and lsu_rdata=0xDEADBEEF in cycle N+1.
REQ-033 Both ports request stores every cycle (RR build) -> grants alternate LSU, EXT, LSU, EXT; mem_mask follows each winner's mask (e.g. 0x1, then 0xF).
REQ-034 Both ports request in the fixed-priority build -> lsu_gnt every cycle and ext_gnt=0 until lsu_req drops.
REQ-035 Back-to-back: LSU load then EXT load in consecutive cycles, mem_rdata 0x11 then 0x22 -> lsu_rvalid with 0x11 in cycle N+1, ext_rvalid with 0x22 in cycle N+2, no bubble.
REQ-036 Assert rst_n in the cycle after an LSU load grant -> lsu_rvalid never asserts, and all outputs equal their REQ-026 reset values.
